// File: rtl/regfile_dump_reader_pkg.sv
// Codebase-wide register file geometry and dump-reader FSM state encoding.
package regfile_dump_reader_pkg;

  localparam int unsigned RF_DATA_WIDTH = 16;
  localparam int unsigned RF_ADDR_WIDTH = 4;
  localparam int unsigned RF_NUM_REGS   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StSendA,
    StSendB,
    StDone
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file in even/odd pairs, snapshots each pair and streams
// the values with their register numbers over a valid/ready debug port.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = RF_NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Abort,
  output logic [ADDR_WIDTH-1:0] ReadA,
  output logic [ADDR_WIDTH-1:0] ReadB,
  input  logic [DATA_WIDTH-1:0] OutA,
  input  logic [DATA_WIDTH-1:0] OutB,
  output logic [DATA_WIDTH-1:0] DumpData,
  output logic [ADDR_WIDTH-1:0] DumpReg,
  output logic                  DumpValid,
  input  logic                  DumpReady,
  output logic                  Busy,
  output logic                  Done
);

  localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS / 2 - 1);

  dump_state_e           state;
  logic [IDX_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] hold_a;
  logic [DATA_WIDTH-1:0] hold_b;
  logic                  dump_valid;
  logic                  busy;
  logic                  done;

  // Addresses come straight from the pair index, so OutA/OutB settle a full
  // cycle before the CAPTURE edge.
  assign ReadA = {idx, 1'b0};
  assign ReadB = {idx, 1'b1};

  assign DumpData  = (state == StSendB) ? hold_b : hold_a;
  assign DumpReg   = (state == StSendB) ? ReadB : ReadA;
  assign DumpValid = dump_valid;
  assign Busy      = busy;
  assign Done      = done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      idx        <= '0;
      hold_a     <= '0;
      hold_b     <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (Abort && (state != StIdle)) begin
      state      <= StIdle;
      idx        <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (Start && !Abort) begin
            state <= StCapture;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        StCapture: begin
          hold_a     <= OutA;
          hold_b     <= OutB;
          dump_valid <= 1'b1;
          state      <= StSendA;
        end
        StSendA: begin
          if (DumpReady) state <= StSendB;
        end
        StSendB: begin
          if (DumpReady) begin
            dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= StCapture;
            end
          end
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised scoreboard bench: a behavioural register file feeds the reader and
// every accepted beat is checked against the register contents seen at Start.
module tb_regfile_dump_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        Start;
  logic        Abort;
  logic [3:0]  ReadA;
  logic [3:0]  ReadB;
  logic [15:0] OutA;
  logic [15:0] OutB;
  logic [15:0] DumpData;
  logic [3:0]  DumpReg;
  logic        DumpValid;
  logic        DumpReady;
  logic        Busy;
  logic        Done;

  logic [15:0] rf [16];
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;

  logic [19:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int beats = 0;
  int done_seen = 0;

  always #5 clock = ~clock;

  // Register file: combinational read, write at the edge (read-before-write).
  always @(posedge clock) if (we) rf[waddr] <= wdata;
  assign OutA = rf[ReadA];
  assign OutB = rf[ReadB];

  regfile_dump_reader dut (
    .clock     (clock),
    .reset     (reset),
    .Start     (Start),
    .Abort     (Abort),
    .ReadA     (ReadA),
    .ReadB     (ReadB),
    .OutA      (OutA),
    .OutB      (OutB),
    .DumpData  (DumpData),
    .DumpReg   (DumpReg),
    .DumpValid (DumpValid),
    .DumpReady (DumpReady),
    .Busy      (Busy),
    .Done      (Done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // A dump yields every register, in order, as it stood when Start was issued.
  task automatic push_expect();
    for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), rf[r]});
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    we = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic preload(input bit rnd);
    for (int r = 0; r < 16; r++) begin
      if (rnd) write_reg(4'(r), 16'($urandom));
      else if (r == 1) write_reg(4'(r), 16'h000A);
      else if (r == 2) write_reg(4'(r), 16'hFF38);
      else write_reg(4'(r), 16'(r * 16'h0101));
    end
  endtask

  task automatic start_dump();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready.
  task automatic run(input int mode, input bit poke);
    bit fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      case (mode)
        0: DumpReady = 1'b1;
        1: DumpReady = (c % 4 == 0) || (c % 4 == 3);
        default: DumpReady = 1'($urandom_range(0, 1));
      endcase
      Start = poke && ((c == 10) || Done);
      tick();
      if (!Busy) fin = 1'b1;
    end
    Start = 1'b0;
    DumpReady = 1'b1;
    check("run_completes", {31'd0, fin}, 32'd1);
  endtask

  // Advance with ready high until register r is presented, then stall it.
  task automatic wait_reg(input logic [3:0] r);
    bit found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (DumpValid && DumpReg == r) begin
        found = 1'b1;
        DumpReady = 1'b0;
      end else begin
        DumpReady = 1'b1;
        tick();
      end
    end
    check("wait_reg_reached", {31'd0, found}, 32'd1);
  endtask

  task automatic monitor();
    logic        stall = 1'b0;
    logic [15:0] pd = '0;
    logic [3:0]  pr = '0;
    logic [19:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (Done) done_seen++;
        if (stall && DumpValid) check("stall_hold", {12'd0, DumpReg, DumpData}, {12'd0, pr, pd});
        if (DumpValid && DumpReady) begin
          beats++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {12'd0, DumpReg, DumpData}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat", {12'd0, DumpReg, DumpData}, {12'd0, e});
          end
        end
        stall = DumpValid && !DumpReady;
        pd = DumpData;
        pr = DumpReg;
      end
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_ReadA"}, {28'd0, ReadA}, 32'd0);
    check({tag, "_ReadB"}, {28'd0, ReadB}, 32'd1);
    check({tag, "_DumpValid"}, {31'd0, DumpValid}, 32'd0);
    check({tag, "_Busy"}, {31'd0, Busy}, 32'd0);
    check({tag, "_Done"}, {31'd0, Done}, 32'd0);
    check({tag, "_DumpData"}, {16'd0, DumpData}, 32'd0);
    check({tag, "_DumpReg"}, {28'd0, DumpReg}, 32'd0);
  endtask

  initial begin
    int d0;
    int b0;
    fork
      monitor();
    join_none

    reset = 1'b1;
    Start = 1'b0;
    Abort = 1'b0;
    DumpReady = 1'b1;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    tick();
    preload(1'b0);
    tick();
    reset = 1'b0;
    check_outputs_reset("reset");

    // Ready tied high: latency and cycle positions of Done/Busy.
    d0 = done_seen;
    push_expect();
    start_dump();
    for (int k = 1; k <= 26; k++) begin
      if (k == 1) begin
        check("lat_capture_valid", {31'd0, DumpValid}, 32'd0);
        check("lat_capture_busy", {31'd0, Busy}, 32'd1);
      end
      if (k == 2) check("lat_first_valid", {31'd0, DumpValid}, 32'd1);
      if (k == 24) check("lat_done_early", {31'd0, Done}, 32'd0);
      if (k == 25) begin
        check("lat_done", {31'd0, Done}, 32'd1);
        check("lat_done_busy", {31'd0, Busy}, 32'd1);
      end
      if (k == 26) begin
        check("lat_busy_drop", {31'd0, Busy}, 32'd0);
        check("lat_done_pulse", {31'd0, Done}, 32'd0);
      end
      if (k < 26) tick();
    end
    tick();
    check("t1_all_beats", exp_q.size(), 32'd0);
    check("t1_done_count", done_seen - d0, 32'd1);

    // Toggling ready.
    d0 = done_seen;
    b0 = beats;
    push_expect();
    start_dump();
    run(1, 1'b0);
    tick();
    check("t2_all_beats", exp_q.size(), 32'd0);
    check("t2_beat_count", beats - b0, 32'd16);
    check("t2_done_count", done_seen - d0, 32'd1);

    // Writes at and after the pair-1 capture edge must not reach the dump.
    d0 = done_seen;
    push_expect();
    DumpReady = 1'b1;
    start_dump();
    repeat (3) tick();
    we = 1'b1;
    waddr = 4'd3;
    wdata = 16'h1234;
    tick();
    wdata = 16'h5555;
    tick();
    we = 1'b0;
    run(0, 1'b0);
    tick();
    check("t3_all_beats", exp_q.size(), 32'd0);
    check("t3_done_count", done_seen - d0, 32'd1);

    // Abort during SEND_B of pair 4, then restart from register 0.
    d0 = done_seen;
    push_expect();
    start_dump();
    wait_reg(4'd9);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_valid", {31'd0, DumpValid}, 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    exp_q.delete();
    repeat (3) tick();
    check("abort_no_done", done_seen - d0, 32'd0);
    d0 = done_seen;
    push_expect();
    start_dump();
    run(2, 1'b0);
    tick();
    check("restart_all_beats", exp_q.size(), 32'd0);
    check("restart_done", done_seen - d0, 32'd1);

    // Start while busy and in the DONE cycle is ignored.
    d0 = done_seen;
    b0 = beats;
    push_expect();
    start_dump();
    run(1, 1'b1);
    tick();
    check("t5_not_restarted", {31'd0, Busy}, 32'd0);
    tick();
    check("t5_still_idle", {31'd0, Busy}, 32'd0);
    check("t5_beat_count", beats - b0, 32'd16);
    check("t5_done_count", done_seen - d0, 32'd1);

    // Random contents with random back-pressure.
    for (int it = 0; it < 3; it++) begin
      d0 = done_seen;
      preload(1'b1);
      push_expect();
      start_dump();
      run(2, 1'b0);
      tick();
      check("rand_all_beats", exp_q.size(), 32'd0);
      check("rand_done", done_seen - d0, 32'd1);
    end

    // Reset during SEND_A of pair 2.
    d0 = done_seen;
    push_expect();
    start_dump();
    wait_reg(4'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs_reset("midreset");
    exp_q.delete();
    DumpReady = 1'b1;
    repeat (3) tick();
    check("midreset_no_done", done_seen - d0, 32'd0);

    // Start and Abort together in IDLE.
    Start = 1'b1;
    Abort = 1'b1;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    check("start_abort_busy", {31'd0, Busy}, 32'd0);
    tick();
    check("start_abort_idle", {31'd0, Busy}, 32'd0);
    check("start_abort_valid", {31'd0, DumpValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side initiator for the 16x16 register file: on a Start pulse it drives ReadA/ReadB to walk every register in even/odd pairs.
- Captures OutA/OutB and streams each value, tagged with its register number, over a valid/ready debug interface.
- Sits beside the CPU datapath on the debug/trace path; the bench uses it as a scoreboard for register contents.
- It never writes the register file.

Parameters:
- DATA_WIDTH, 16, register data width; matches register file InData/OutA/OutB.
- ADDR_WIDTH, 4, register address width.
- NUM_REGS, 16, registers walked, 0..NUM_REGS-1. Must be even and at most 2**ADDR_WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- Start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- Abort  input  1  terminate the dump; returns to IDLE on the next edge.
- ReadA  output ADDR_WIDTH  register file read address A; always even.
- ReadB  output ADDR_WIDTH  register file read address B; always ReadA+1.
- OutA  input  DATA_WIDTH  register file read data A; combinational from ReadA.
- OutB  input  DATA_WIDTH  register file read data B.
- DumpData  output DATA_WIDTH  streamed register value.
- DumpReg  output ADDR_WIDTH  register number of DumpData.
- DumpValid  output 1  DumpData/DumpReg valid.
- DumpReady  input  1  consumer accepts the beat when DumpValid and DumpReady are both high at an edge.
- Busy  output 1  high in every state except IDLE.
- Done  output 1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset, and the power-on state after the first reset edge:
  - state=IDLE, pair index idx=0, so ReadA=0 and ReadB=1.
  - holdA=holdB=0, DumpData=0, DumpReg=0.
  - DumpValid=0, Busy=0, Done=0.
- A reset asserted mid-dump returns everything to these values at that edge. The partial dump is discarded and no Done is produced.
- ReadA={idx,0} and ReadB={idx,1}, decoded from the registered idx; no combinational path from any input.
- FSM:
  - IDLE: Start=1 and Abort=0 -> CAPTURE, idx=0.
  - CAPTURE (1 cycle): ReadA/ReadB are stable. At the edge, holdA<=OutA, holdB<=OutB, then -> SEND_A.
  - SEND_A: DumpValid=1, DumpData=holdA, DumpReg=ReadA. On DumpReady -> SEND_B.
  - SEND_B: DumpValid=1, DumpData=holdB, DumpReg=ReadB. On DumpReady:
    - if idx==NUM_REGS/2-1 -> DONE;
    - else idx<=idx+1 and -> CAPTURE.
  - DONE (1 cycle): Done=1, Busy=1, then -> IDLE with idx=0.
- Handshake: while DumpValid=1 and DumpReady=0, DumpData and DumpReg hold stable indefinitely. DumpValid never drops without acceptance, except on Abort or reset.
- Latency:
  - Start sampled at edge N: CAPTURE occupies cycle N+1 and the first DumpValid is in cycle N+2.
  - With DumpReady tied high: 3 cycles per pair, so 8 pairs = 24 cycles. Done is high in cycle N+25 and Busy drops in cycle N+26.
- Snapshot semantics: each pair is sampled in its CAPTURE cycle. A register-file write landing after that capture is not reflected. Same-cycle write/read ordering follows the register file (read-before-write at that edge).
- Abort:
  - From any non-IDLE state, go to IDLE at the next edge: DumpValid=0, idx=0, no Done.
  - In IDLE, Abort has no effect. Abort wins over Start in the same cycle.
- Start is ignored while Busy, including in DONE; it is not queued.
- Arithmetic: idx is ADDR_WIDTH-1 bits and compares against NUM_REGS/2-1 only; it never wraps past that value. Data is passed unmodified; the signed interpretation is left to the consumer.

Decomposition:
- Shared header/package: FSM state encodings (IDLE, CAPTURE, SEND_A, SEND_B, DONE), DATA_WIDTH=16, ADDR_WIDTH=4 and NUM_REGS=16 as codebase-wide constants, shared with the register file.
- No sub-module: the FSM, idx counter and two hold registers form a single module.
- The bench instantiates the existing register file and wires ReadA/ReadB/OutA/OutB directly.

Test Plan:
- Preload R1=0x000A, R2=0xFF38 (-200), all others Rn=n*0x0101. Start with DumpReady=1 -> 16 beats with DumpReg 0..15 in order: beat1=(1,0x000A), beat2=(2,0xFF38), beat15=(15,0x0F0F). Done in cycle N+25; Busy low from N+26.
- Same preload, DumpReady toggling 1,0,0,1 repeatedly -> same 16 beats in the same order. Data/reg stable during stalls; no beat duplicated or dropped.
- Write R3=0x1234 during the pair-1 CAPTURE edge, then R3=0x5555 during the SEND_A of pair 1 -> R3 beat shows the value stored before the capture edge, never 0x5555.
- Abort during SEND_B of pair 4 (DumpReg=9) -> next cycle DumpValid=0, Busy=0, no Done. A new Start restarts from DumpReg=0.
- Start pulsed again while Busy, and in the DONE cycle -> ignored: exactly 16 beats and one Done pulse.
- Assert reset in SEND_A of pair 2 -> next edge all outputs at reset values (ReadA=0, ReadB=1, DumpValid=0). Start and Abort asserted together in IDLE -> remains IDLE.
